// File: rtl/sw_sequencer_if.sv
// Button inputs and sequencer control outputs for the stopwatch sequencer.
interface sw_sequencer_if;
    logic       btn_start;
    logic       btn_pause;
    logic       btn_lap;
    logic       run;
    logic       cnt_clr;
    logic       freeze;
    logic       lap_load;
    logic [3:0] lap_count;
    logic [1:0] state;

    modport master (
        output btn_start, btn_pause, btn_lap,
        input  run, cnt_clr, freeze, lap_load, lap_count, state
    );

    modport slave (
        input  btn_start, btn_pause, btn_lap,
        output run, cnt_clr, freeze, lap_load, lap_count, state
    );
endinterface

// File: rtl/sw_sequencer.sv
// Stopwatch control sequencer: synchronizes and debounces three buttons,
// then steps an IDLE/RUN/PAUSED/LAP machine driving timer control outputs.
module sw_sequencer #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic          clk,
    input  logic          clr,
    sw_sequencer_if.slave bus
);
    localparam int unsigned NUM_BTN   = 3;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned LAP_W     = 4;
    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_PAUSE = 1;
    localparam int unsigned BTN_LAP   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        LAP    = 2'b11
    } state_e;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [CNT_W-1:0]   db_cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   db_cnt_d [NUM_BTN];

    state_e             state_q, state_d;
    logic               run_q, run_d;
    logic               freeze_q, freeze_d;
    logic               lap_load_q, lap_load_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic [LAP_W-1:0]   lap_count_q, lap_count_d;

    logic               ev_start, ev_pause, ev_lap;

    assign raw = {bus.btn_lap, bus.btn_pause, bus.btn_start};

    // Synchronize, debounce and edge-detect each button independently
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                level_d[i]  = ~level_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    // Fixed priority pause > lap > start; losers are dropped even if the winner is ignored
    assign ev_pause = press_q[BTN_PAUSE];
    assign ev_lap   = press_q[BTN_LAP] & ~press_q[BTN_PAUSE];
    assign ev_start = press_q[BTN_START] & ~press_q[BTN_LAP] & ~press_q[BTN_PAUSE];

    always_comb begin
        state_d     = state_q;
        lap_load_d  = 1'b0;
        cnt_clr_d   = 1'b0;
        lap_count_d = lap_count_q;
        unique case (state_q)
            IDLE: begin
                if (ev_start) state_d = RUN;
            end
            RUN: begin
                if (ev_pause) begin
                    state_d = PAUSED;
                end else if (ev_lap) begin
                    state_d    = LAP;
                    lap_load_d = 1'b1;
                    if (lap_count_q != {LAP_W{1'b1}}) lap_count_d = lap_count_q + LAP_W'(1);
                end
            end
            LAP: begin
                if (ev_pause) begin
                    state_d = PAUSED;
                end else if (ev_lap) begin
                    state_d    = RUN;
                    lap_load_d = 1'b1;
                end
            end
            PAUSED: begin
                if (ev_lap) begin
                    state_d     = IDLE;
                    cnt_clr_d   = 1'b1;
                    lap_count_d = '0;
                end else if (ev_start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        run_d    = (state_d == RUN) || (state_d == LAP);
        freeze_d = (state_d == LAP);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            press_q     <= '0;
            for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
            state_q     <= IDLE;
            run_q       <= 1'b0;
            freeze_q    <= 1'b0;
            lap_load_q  <= 1'b0;
            cnt_clr_q   <= 1'b0;
            lap_count_q <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            press_q     <= press_d;
            for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q     <= state_d;
            run_q       <= run_d;
            freeze_q    <= freeze_d;
            lap_load_q  <= lap_load_d;
            cnt_clr_q   <= cnt_clr_d;
            lap_count_q <= lap_count_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.run       = run_q;
    assign bus.freeze    = freeze_q;
    assign bus.lap_load  = lap_load_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.lap_count = lap_count_q;
endmodule

// File: doc/sw_sequencer.md
SW_SEQUENCER -- requirements
Module: sw_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 16, consecutive clocks a synchronized button level must hold before it is accepted (legal range 2..255).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 clr  input  1  synchronous, active-high reset.
REQ-004 btn_start  input  1  raw, asynchronous start button, active-high.
REQ-005 btn_pause  input  1  raw, asynchronous pause button, active-high.
REQ-006 btn_lap  input  1  raw, asynchronous lap/reset button, active-high.
REQ-007 run  output  1  count-enable level to the timer datapath.
REQ-008 cnt_clr  output  1  one-cycle pulse that clears the timer datapath.
REQ-009 freeze  output  1  display-hold level; the digit path keeps its last value while high.
REQ-010 lap_load  output  1  one-cycle pulse that captures the current time into the lap register.
REQ-011 lap_count  output  4  number of laps taken since the last clear.
REQ-012 state  output  2  current state: IDLE=00, RUN=01, PAUSED=10, LAP=11.

Function
REQ-013 Each button SHALL pass through its own 2-flop synchronizer.
REQ-014 Each button SHALL have a debounce counter that counts cycles while the synchronized value differs from the accepted level, and zeroes whenever they match.
REQ-015 The accepted level SHALL flip on the DB_CYCLES-th consecutive differing cycle, and the counter SHALL then zero.
REQ-016 A press event SHALL be a registered one-cycle pulse on an accepted 0->1 transition; a release SHALL generate no event.
REQ-017 Latency: for a raw button rising before edge 1 and held, the state register SHALL update at edge DB_CYCLES+3.
REQ-018 Glitches shorter than DB_CYCLES synchronized cycles SHALL produce no event.
REQ-019 When press events coincide in one cycle, priority SHALL be pause > lap > start; lower-priority events that cycle SHALL be discarded.
REQ-020 IDLE: start -> RUN; pause and lap are ignored.
REQ-021 RUN: pause -> PAUSED; lap -> LAP with lap_load pulsed; start is ignored.
REQ-022 LAP: lap -> RUN with lap_load pulsed; pause -> PAUSED; start is ignored.
REQ-023 PAUSED: start -> RUN; lap -> IDLE with cnt_clr pulsed; pause is ignored.
REQ-024 Output decoding from state:
- run=1 in RUN and LAP, run=0 in IDLE and PAUSED.
- freeze=1 only in LAP.
REQ-025 All outputs SHALL be registered.
REQ-026 lap_load and cnt_clr SHALL be high exactly during the cycle in which the new state first appears on state.
REQ-027 lap_count SHALL increment on each RUN->LAP transition, saturating at 15.
REQ-028 lap_count SHALL zero in the cycle IDLE is entered via cnt_clr.
REQ-029 lap_count SHALL hold through PAUSED.

Reset
REQ-030 While clr=1 at a clock edge, the block SHALL clear all of the following on that edge:
- state=IDLE.
- run, freeze, lap_load, cnt_clr and lap_count all 0.
- synchronizers, accepted levels and debounce counters all 0.
REQ-031 clr SHALL take precedence over any press event in the same cycle.
REQ-032 clr asserted mid-debounce SHALL discard the partial count.
REQ-033 A button still held when clr deasserts SHALL be re-debounced from zero, and SHALL produce a press event once accepted.
REQ-034 cnt_clr SHALL NOT pulse on clr; the timer takes clr directly.

Verification (DB_CYCLES=4)
REQ-035 clr for 2 cycles, then btn_start high for 10 cycles -> state=01 and run=1 at edge 7 after release of clr; cnt_clr stays 0.
REQ-036 From RUN, btn_pause pulse 3 cycles wide -> no state change; pulse 6 wide -> state=10, run=0.
REQ-037 From RUN, lap pressed twice (each 6 cycles, separated by 10) -> RUN->LAP->RUN, lap_load high exactly 2 cycles total, lap_count=1, freeze high only while state=11.
REQ-038 From PAUSED, lap pressed -> state=00, cnt_clr high 1 cycle, lap_count=0; a further lap press in IDLE -> no change.
REQ-039 Pause, lap and start raw-asserted in the same cycle from RUN -> state=10 only, lap_load=0.
REQ-040 16 RUN->LAP cycles -> lap_count saturates at 15; clr asserted mid-press -> all outputs 0 next cycle, held button accepted DB_CYCLES+2 edges after clr drops.
